// File: rtl/smg_pkg.sv
`default_nettype none
//==============================================================================
// smg_pkg -- segment code constants and hex-to-segment lookup (active-low)
// Revision 1.0
//==============================================================================
package smg_pkg;

   localparam logic [6:0] SEG_0     = 7'h01;
   localparam logic [6:0] SEG_1     = 7'h4F;
   localparam logic [6:0] SEG_2     = 7'h12;
   localparam logic [6:0] SEG_3     = 7'h06;
   localparam logic [6:0] SEG_4     = 7'h4C;
   localparam logic [6:0] SEG_5     = 7'h24;
   localparam logic [6:0] SEG_6     = 7'h20;
   localparam logic [6:0] SEG_7     = 7'h0F;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h04;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h60;
   localparam logic [6:0] SEG_C     = 7'h31;
   localparam logic [6:0] SEG_D     = 7'h42;
   localparam logic [6:0] SEG_E     = 7'h30;
   localparam logic [6:0] SEG_F     = 7'h38;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
      logic [6:0] code;
      code = SEG_BLANK;
      case (nibble)
         4'h0:    code = SEG_0;
         4'h1:    code = SEG_1;
         4'h2:    code = SEG_2;
         4'h3:    code = SEG_3;
         4'h4:    code = SEG_4;
         4'h5:    code = SEG_5;
         4'h6:    code = SEG_6;
         4'h7:    code = SEG_7;
         4'h8:    code = SEG_8;
         4'h9:    code = SEG_9;
         4'hA:    code = SEG_A;
         4'hB:    code = SEG_B;
         4'hC:    code = SEG_C;
         4'hD:    code = SEG_D;
         4'hE:    code = SEG_E;
         default: code = SEG_F;
      endcase
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/smg_scan_if.sv
`default_nettype none
//==============================================================================
// smg_scan_if -- display data/control inputs and digit/segment pin outputs
// Revision 1.0
//==============================================================================
interface smg_scan_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] disp_data;
   logic [DIGITS-1:0]   digit_en;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   blink_en;
   logic                lz_sup;
   logic [3:0]          bright;
   logic                load;
   logic [DIGITS-1:0]   seg_sel;
   logic [6:0]          seg_ment;
   logic                seg_dp;
   logic                frame_done;

   modport master (
      output disp_data, digit_en, dp, blink_en, lz_sup, bright, load,
      input  seg_sel, seg_ment, seg_dp, frame_done
   );

   modport slave (
      input  disp_data, digit_en, dp, blink_en, lz_sup, bright, load,
      output seg_sel, seg_ment, seg_dp, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/smg_hex_decode.sv
`default_nettype none
//==============================================================================
// smg_hex_decode -- registered nibble-to-segment decoder with blank override
// Revision 1.0
//==============================================================================
module smg_hex_decode
   import smg_pkg::*;
#(
   parameter bit SEG_ACT_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);
   localparam logic [6:0] POL = SEG_ACT_LOW ? 7'h00 : 7'h7F;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_BLANK ^ POL;
      end else begin
         seg <= (blank ? SEG_BLANK : hex2seg(nibble)) ^ POL;
      end
   end
endmodule
`default_nettype wire

// File: rtl/smg_scan.sv
`default_nettype none
//==============================================================================
// smg_scan -- multiplexed seven-segment scan driver with frame-synchronous loads
// Revision 1.0
//==============================================================================
module smg_scan
   import smg_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int SCAN_CYC     = 100_000,
   parameter int BLINK_FRAMES = 32,
   parameter bit SEL_ACT_LOW  = 1'b1,
   parameter bit SEG_ACT_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   smg_scan_if.slave  bus
);
   localparam int IDX_W   = $clog2(DIGITS);
   localparam int SLOT_W  = $clog2(SCAN_CYC);
   localparam int FRM_W   = $clog2(BLINK_FRAMES + 1);
   localparam int SUB_LEN = SCAN_CYC / 16;
   localparam int CFG_W   = 7 * DIGITS + 5;

   logic [CFG_W-1:0]    cfg_in;
   logic [CFG_W-1:0]    pend;
   logic [CFG_W-1:0]    act;
   logic [4*DIGITS-1:0] act_data;
   logic [DIGITS-1:0]   act_en;
   logic [DIGITS-1:0]   act_dp;
   logic [DIGITS-1:0]   act_blink;
   logic                act_lz;
   logic [3:0]          act_bright;

   logic [SLOT_W-1:0]   slot_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic [FRM_W-1:0]    frame_cnt;
   logic                blink_phase;
   logic                slot_end;
   logic                wrap;
   logic [DIGITS-1:0]   supp;
   logic [3:0]          sub;
   logic [3:0]          nibble;
   logic                lit;
   logic [DIGITS-1:0]   sel_hot;

   // Packed snapshot of every display control; pending and active hold this layout.
   assign cfg_in = {bus.disp_data, bus.digit_en, bus.dp, bus.blink_en, bus.lz_sup, bus.bright};
   assign {act_data, act_en, act_dp, act_blink, act_lz, act_bright} = act;

   assign slot_end = (slot_cnt == SLOT_W'(SCAN_CYC - 1));
   assign wrap     = slot_end && (digit_idx == IDX_W'(DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt    <= '0;
         digit_idx   <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
         if (slot_end) begin
            digit_idx <= wrap ? '0 : digit_idx + 1'b1;
         end
         if (wrap) begin
            if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // A load landing on the wrap cycle bypasses pending so it is not lost a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         act  <= '0;
      end else begin
         if (bus.load) begin
            pend <= cfg_in;
         end
         if (wrap) begin
            act <= bus.load ? cfg_in : pend;
         end
      end
   end

   always_comb begin
      logic run;
      run  = act_lz;
      supp = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (act_en[i]) begin
            if (run && (act_data[4*i +: 4] == 4'h0) && !act_dp[i]) begin
               supp[i] = 1'b1;
            end else begin
               run = 1'b0;
            end
         end
      end
   end

   assign sub    = 4'(slot_cnt / SLOT_W'(SUB_LEN));
   assign nibble = act_data[{digit_idx, 2'b00} +: 4];
   assign lit    = act_en[digit_idx] && !supp[digit_idx] && (sub <= act_bright)
                   && !(act_blink[digit_idx] && !blink_phase);

   always_comb begin
      sel_hot            = '0;
      sel_hot[digit_idx] = lit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.seg_sel    <= {DIGITS{SEL_ACT_LOW}};
         bus.seg_dp     <= SEG_ACT_LOW;
         bus.frame_done <= 1'b0;
      end else begin
         bus.seg_sel    <= sel_hot ^ {DIGITS{SEL_ACT_LOW}};
         bus.seg_dp     <= (lit && act_dp[digit_idx]) ^ SEG_ACT_LOW;
         bus.frame_done <= wrap;
      end
   end

   smg_hex_decode #(
      .SEG_ACT_LOW (SEG_ACT_LOW)
   ) u_decode (
      .clk    (clk),
      .rst_n  (rst_n),
      .nibble (nibble),
      .blank  (!lit),
      .seg    (bus.seg_ment)
   );
endmodule
`default_nettype wire
